// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_signed_a(input logic [2:0] f3);
        return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    endfunction

endpackage

// File: rtl/muldiv_sign_adjust.sv
// Conditional two's-complement negate, used for operand magnitude
// and for the final sign fix-up of the result.
module muldiv_sign_adjust #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring
// divide, one bit per cycle, with stall and done handshakes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH             = 32,
    parameter int REGISTER_ADDRESS_WIDTH = 5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              startE_i,
    input  logic [2:0]                        funct3E_i,
    input  logic [DATA_WIDTH-1:0]             srcAE_i,
    input  logic [DATA_WIDTH-1:0]             srcBE_i,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] AD3E_i,
    input  logic                              flushE_i,
    output logic                              busy_o,
    output logic                              doneM_o,
    output logic [DATA_WIDTH-1:0]             resultM_o,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] AD3M_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam int RW = REGISTER_ADDRESS_WIDTH;

    muldiv_state_t   state_q;
    logic [CW-1:0]   cnt_q;
    logic [2*W-1:0]  acc_q;
    logic [W-1:0]    opnd_q;
    logic [2:0]      op_q;
    logic            neg_q;
    logic [RW-1:0]   rd_q;
    logic            done_q;
    logic [W-1:0]    res_q;
    logic [RW-1:0]   ad3m_q;

    logic            sign_a;
    logic            sign_b;
    logic            neg_d;
    logic            div_zero;
    logic            div_ovf;
    logic [W-1:0]    spec_res;
    logic [W-1:0]    abs_b;
    logic [2*W-1:0]  adj_in;
    logic [2*W-1:0]  adj_out;
    logic            adj_neg;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [W:0]      div_trial;
    logic [2*W-1:0]  div_next;
    logic [2*W-1:0]  step_next;
    logic [W-1:0]    final_res;
    logic            last;

    assign busy_o    = (state_q == S_MUL) || (state_q == S_DIV);
    assign doneM_o   = done_q;
    assign resultM_o = res_q;
    assign AD3M_o    = ad3m_q;

    assign sign_a = is_signed_a(funct3E_i) & srcAE_i[W-1];
    assign sign_b = is_signed_b(funct3E_i) & srcBE_i[W-1];
    assign neg_d  = (funct3E_i[2] & funct3E_i[1]) ? sign_a : (sign_a ^ sign_b);

    assign div_zero = funct3E_i[2] && (srcBE_i == '0);
    assign div_ovf  = funct3E_i[2] && !funct3E_i[0]
                   && (srcAE_i == {1'b1, {(W-1){1'b0}}})
                   && (srcBE_i == '1);
    assign spec_res = div_zero ? (funct3E_i[1] ? srcAE_i : '1)
                               : (funct3E_i[1] ? '0 : srcAE_i);

    // One shift-add step: carry of the upper-half add shifts back in.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]}
                               : {1'b0, acc_q[2*W-1:W], acc_q[W-1:1]};

    assign div_trial = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, opnd_q};
    assign div_next  = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                                    : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};

    assign step_next = (state_q == S_MUL) ? mul_next : div_next;
    assign last      = (cnt_q == CW'(W - 1));

    // The wide adjuster takes |srcA| at accept and the fix-up while busy.
    always_comb begin
        adj_in  = {{W{1'b0}}, srcAE_i};
        adj_neg = sign_a;
        if (busy_o) begin
            adj_neg = neg_q;
            if (state_q == S_MUL)
                adj_in = step_next;
            else if (op_q[1])
                adj_in = {{W{1'b0}}, step_next[2*W-1:W]};
            else
                adj_in = {{W{1'b0}}, step_next[W-1:0]};
        end
    end

    always_comb begin
        final_res = adj_out[W-1:0];
        if (state_q == S_MUL && op_q != F3_MUL)
            final_res = adj_out[2*W-1:W];
    end

    muldiv_sign_adjust #(.W(2*W)) u_adj (
        .val_i (adj_in),
        .neg_i (adj_neg),
        .val_o (adj_out)
    );

    muldiv_sign_adjust #(.W(W)) u_abs_b (
        .val_i (srcBE_i),
        .neg_i (sign_b),
        .val_o (abs_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rd_q    <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
            ad3m_q  <= '0;
        end else if (flushE_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (startE_i) begin
                        op_q  <= funct3E_i;
                        neg_q <= neg_d;
                        rd_q  <= AD3E_i;
                        cnt_q <= '0;
                        if (div_zero || div_ovf) begin
                            res_q   <= spec_res;
                            ad3m_q  <= AD3E_i;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (funct3E_i[2]) begin
                            acc_q   <= {{W{1'b0}}, adj_out[W-1:0]};
                            opnd_q  <= abs_b;
                            state_q <= S_DIV;
                        end else begin
                            acc_q   <= {{W{1'b0}}, abs_b};
                            opnd_q  <= adj_out[W-1:0];
                            state_q <= S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc_q <= step_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        res_q   <= final_res;
                        ad3m_q  <= rd_q;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against an arithmetic model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        startE_i;
    logic [2:0]  funct3E_i;
    logic [31:0] srcAE_i;
    logic [31:0] srcBE_i;
    logic [4:0]  AD3E_i;
    logic        flushE_i;
    logic        busy_o;
    logic        doneM_o;
    logic [31:0] resultM_o;
    logic [4:0]  AD3M_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    logic [31:0] last_exp = '0;

    muldiv_unit #(
        .DATA_WIDTH(32),
        .REGISTER_ADDRESS_WIDTH(5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .startE_i  (startE_i),
        .funct3E_i (funct3E_i),
        .srcAE_i   (srcAE_i),
        .srcBE_i   (srcBE_i),
        .AD3E_i    (AD3E_i),
        .flushE_i  (flushE_i),
        .busy_o    (busy_o),
        .doneM_o   (doneM_o),
        .resultM_o (resultM_o),
        .AD3M_o    (AD3M_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one op at the current negedge and waits for its done pulse.
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        int lat;
        int busy_cnt;
        logic special;
        logic [31:0] exp;
        special = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000
                                       && b == 32'hFFFF_FFFF));
        exp = model(f3, a, b);
        startE_i  = 1'b1;
        funct3E_i = f3;
        srcAE_i   = a;
        srcBE_i   = b;
        AD3E_i    = rd;
        @(posedge clk);
        @(negedge clk);
        startE_i = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!doneM_o && lat < 40) begin
            if (busy_o) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        last_done_cyc = cyc;
        chk({tag, " done"}, 32'(doneM_o), 32'd1);
        chk({tag, " result"}, resultM_o, exp);
        chk({tag, " rd"}, 32'(AD3M_o), 32'(rd));
        chk({tag, " latency"}, 32'(lat), special ? 32'd0 : 32'd32);
        chk({tag, " busy cycles"}, 32'(busy_cnt), special ? 32'd0 : 32'd32);
        last_exp = exp;
    endtask

    initial begin
        int d1;
        int seen;
        logic [2:0] f3;
        logic [31:0] a;
        logic [31:0] b;
        rst_n     = 1'b0;
        startE_i  = 1'b0;
        funct3E_i = '0;
        srcAE_i   = '0;
        srcBE_i   = '0;
        AD3E_i    = '0;
        flushE_i  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset done", 32'(doneM_o), 32'd0);
        chk("reset result", resultM_o, 32'd0);
        chk("reset rd", 32'(AD3M_o), 32'd0);

        run_op("mul 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3);
        run_op("mulhu -1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        run_op("mulh -1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        run_op("mulhsu -1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
        run_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7);
        run_op("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8);
        run_op("divu 100/7", 3'd5, 32'd100, 32'd7, 5'd9);
        run_op("remu 100/7", 3'd7, 32'd100, 32'd7, 5'd10);
        run_op("div 5/0", 3'd4, 32'd5, 32'd0, 5'd11);
        run_op("rem 5/0", 3'd6, 32'd5, 32'd0, 5'd12);
        run_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        run_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
        chk("table mul", model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);

        @(negedge clk);
        startE_i  = 1'b1;
        funct3E_i = 3'd4;
        srcAE_i   = 32'd1000;
        srcBE_i   = 32'd3;
        AD3E_i    = 5'd20;
        @(posedge clk);
        @(negedge clk);
        startE_i = 1'b0;
        repeat (9) @(negedge clk);
        flushE_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flushE_i = 1'b0;
        chk("flush busy", 32'(busy_o), 32'd0);
        chk("flush done", 32'(doneM_o), 32'd0);
        chk("flush result held", resultM_o, last_exp);
        chk("flush rd held", 32'(AD3M_o), 32'd14);
        run_op("mulhu after flush", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21);

        @(negedge clk);
        startE_i  = 1'b1;
        funct3E_i = 3'd0;
        srcAE_i   = 32'd123;
        srcBE_i   = 32'd456;
        AD3E_i    = 5'd22;
        @(posedge clk);
        @(negedge clk);
        startE_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst mid busy", 32'(busy_o), 32'd0);
        chk("rst mid done", 32'(doneM_o), 32'd0);
        chk("rst mid result", resultM_o, 32'd0);
        chk("rst mid rd", 32'(AD3M_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (doneM_o || busy_o) seen++;
        end
        chk("no done after reset", 32'(seen), 32'd0);

        run_op("b2b first", 3'd0, 32'hFFFF_0001, 32'd77, 5'd23);
        d1 = last_done_cyc;
        run_op("b2b second", 3'd7, 32'hDEAD_BEEF, 32'd1000, 5'd24);
        chk("b2b spacing", 32'(last_done_cyc - d1), 32'd33);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op($sformatf("rand%0d f3=%0d", i, f3), f3, a, b,
                   5'($urandom_range(0, 31)));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
